// File: rtl/conv_pkg.sv
// Shared widths and FSM state encodings for the convolution accumulation controller.
package conv_pkg;

    localparam int LEN_IN  = 8;
    localparam int LEN_OUT = 25;
    localparam int CH_W    = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t FETCH = 2'd1;
    localparam state_t ACC   = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/conv_acc_ctrl_if.sv
// Job, window-fetch/MAC and result handshake signals of conv_acc_ctrl.
interface conv_acc_ctrl_if #(
    parameter int LEN_OUT = conv_pkg::LEN_OUT,
    parameter int CH_W    = conv_pkg::CH_W
);

    logic                start;
    logic [CH_W-1:0]     num_ch;
    logic                busy;
    logic                fetch_req;
    logic [CH_W-1:0]     fetch_ch;
    logic                fetch_ack;
    logic [LEN_OUT-1:0]  mac_result;
    logic [LEN_OUT-1:0]  last_result;
    logic                res_valid;
    logic                res_ready;
    logic [LEN_OUT-1:0]  res_data;

    modport master (
        output start, num_ch, fetch_ack, mac_result, res_ready,
        input  busy, fetch_req, fetch_ch, last_result, res_valid, res_data
    );

    modport slave (
        input  start, num_ch, fetch_ack, mac_result, res_ready,
        output busy, fetch_req, fetch_ch, last_result, res_valid, res_data
    );

endinterface

// File: rtl/conv_acc_ctrl.sv
// Sequences per-channel window fetches and accumulates the external 4x4 MAC sum.
// Optional CONV_RELU_EN clamps negative final results to zero on res_data.
module conv_acc_ctrl #(
    parameter int LEN_OUT = conv_pkg::LEN_OUT,
    parameter int CH_W    = conv_pkg::CH_W
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_acc_ctrl_if.slave bus
);
    import conv_pkg::*;

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    num_ch_lat;
    logic [LEN_OUT-1:0] acc;
    logic               last_ch;

    // Comparing against num_ch-1 keeps ch from ever wrapping, even for the largest count.
    assign last_ch = (ch == num_ch_lat - CH_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            acc        <= '0;
            num_ch_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ch <= '0;
                        if (bus.num_ch != '0) begin
                            num_ch_lat <= bus.num_ch;
                            state      <= FETCH;
                        end else begin
                            acc   <= '0;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (bus.fetch_ack) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= bus.mac_result;
                    if (last_ch) begin
                        state <= DONE;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        ch    <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.fetch_req   = (state == FETCH);
    assign bus.fetch_ch    = ch;
    assign bus.last_result = (ch == '0) ? '0 : acc;
    assign bus.res_valid   = (state == DONE);

`ifdef CONV_RELU_EN
    assign bus.res_data = acc[LEN_OUT-1] ? '0 : acc;
`else
    assign bus.res_data = acc;
`endif

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Scoreboard bench for conv_acc_ctrl with a behavioural MAC and random handshakes.
module tb_conv_acc_ctrl;
    import conv_pkg::*;

    localparam int BOUND = 3000;

    logic clk;
    logic rst_n;

    conv_acc_ctrl_if bus ();

    conv_acc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External MAC: the per-channel 16-tap sum added to the controller's feed.
    logic [LEN_OUT-1:0] tap_sum [256];
    assign bus.mac_result = bus.last_result + tap_sum[bus.fetch_ch];

    int tests;
    int fails;
    int fetch_cnt;
    int ack_mode;
    int ready_mode;
    bit noise_en;

    logic [LEN_OUT-1:0] exp_q[$];
    logic [LEN_OUT-1:0] exp_last_q[$];
    logic [CH_W-1:0]    exp_ch_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: event missing or unexpected", name);
    endtask

    // Expected result is the plain modular sum of channel sums; the feed for channel k is the sum of channels before k.
    task automatic prep_job(input int n);
        logic [LEN_OUT-1:0] part;
        part = '0;
        for (int k = 0; k < n; k++) begin
            exp_last_q.push_back(part);
            exp_ch_q.push_back(CH_W'(k));
            part = part + tap_sum[k];
        end
`ifdef CONV_RELU_EN
        if ($signed(part) < 0) part = '0;
`endif
        exp_q.push_back(part);
    endtask

    task automatic run_job(input int n, input int exp_lat);
        int  lat;
        int  base;
        bit  seen;
        prep_job(n);
        base       = fetch_cnt;
        bus.num_ch = CH_W'(n);
        bus.start  = 1'b1;
        lat        = 0;
        seen       = 1'b0;
        while (lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
            if (!seen && bus.res_valid) begin
                seen = 1'b1;
                if (exp_lat >= 0) check_output("latency", 32'(lat), 32'(exp_lat));
            end else if (seen && !bus.res_valid) begin
                break;
            end
            bus.start = noise_en && bus.busy && ($urandom_range(3) == 0);
            if (bus.start) bus.num_ch = CH_W'($urandom);
        end
        bus.start = 1'b0;
        if (lat >= BOUND) report_fail("job_timeout");
        check_output("acc_cycles_left", 32'(exp_last_q.size()), 32'd0);
        check_output("results_left", 32'(exp_q.size()), 32'd0);
        if (n == 0) check_output("fetch_none", 32'(fetch_cnt - base), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"},        32'(bus.busy),        32'd0);
        check_output({tag, "_fetch_req"},   32'(bus.fetch_req),   32'd0);
        check_output({tag, "_fetch_ch"},    32'(bus.fetch_ch),    32'd0);
        check_output({tag, "_last_result"}, 32'(bus.last_result), 32'd0);
        check_output({tag, "_res_valid"},   32'(bus.res_valid),   32'd0);
        check_output({tag, "_res_data"},    32'(bus.res_data),    32'd0);
    endtask

    // Window loader: always ready, random, or a 5-cycle stall on channel 1.
    initial begin
        int stall;
        stall         = 0;
        bus.fetch_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!bus.busy) stall = 0;
            case (ack_mode)
                1: bus.fetch_ack = ($urandom_range(2) == 0);
                2: begin
                    if (bus.fetch_req && bus.fetch_ch == CH_W'(1) && stall < 5) begin
                        bus.fetch_ack = 1'b0;
                        stall++;
                    end else begin
                        bus.fetch_ack = 1'b1;
                    end
                end
                default: bus.fetch_ack = 1'b1;
            endcase
        end
    end

    // Result consumer: always ready, random, or 4 cycles of backpressure per result.
    initial begin
        int hold;
        hold          = 0;
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1: bus.res_ready = ($urandom_range(1) == 0);
                2: begin
                    if (bus.res_valid) begin
                        if (hold < 4) begin
                            bus.res_ready = 1'b0;
                            hold++;
                        end else begin
                            bus.res_ready = 1'b1;
                        end
                    end else begin
                        hold          = 0;
                        bus.res_ready = 1'b0;
                    end
                end
                default: bus.res_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on ACC cycles and accepted results, and checks hold-while-stalled.
    initial begin
        logic               pv_freq, pv_ack, pv_rv, pv_rdy;
        logic [CH_W-1:0]    pv_ch;
        logic [LEN_OUT-1:0] pv_data;
        logic [LEN_OUT-1:0] e;
        logic [CH_W-1:0]    ec;
        fetch_cnt = 0;
        pv_freq = 1'b0; pv_ack = 1'b0; pv_rv = 1'b0; pv_rdy = 1'b0;
        pv_ch = '0; pv_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_freq = 1'b0;
                pv_rv   = 1'b0;
                exp_q.delete();
                exp_last_q.delete();
                exp_ch_q.delete();
            end else begin
                if (pv_freq && !pv_ack) begin
                    check_output("fetch_hold_req", 32'(bus.fetch_req), 32'd1);
                    check_output("fetch_hold_ch",  32'(bus.fetch_ch),  32'(pv_ch));
                end
                if (pv_rv && !pv_rdy) begin
                    check_output("res_hold_valid", 32'(bus.res_valid), 32'd1);
                    check_output("res_hold_data",  32'(bus.res_data),  32'(pv_data));
                end
                if (bus.fetch_req) fetch_cnt++;
                if (bus.busy && !bus.fetch_req && !bus.res_valid) begin
                    if (exp_last_q.size() == 0) begin
                        report_fail("acc_unexpected");
                    end else begin
                        e  = exp_last_q.pop_front();
                        ec = exp_ch_q.pop_front();
                        check_output("last_result", 32'(bus.last_result), 32'(e));
                        check_output("acc_fetch_ch", 32'(bus.fetch_ch), 32'(ec));
                    end
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        report_fail("result_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check_output("res_data", 32'(bus.res_data), 32'(e));
                    end
                end
                pv_freq = bus.fetch_req;
                pv_ack  = bus.fetch_ack;
                pv_ch   = bus.fetch_ch;
                pv_rv   = bus.res_valid;
                pv_rdy  = bus.res_ready;
                pv_data = bus.res_data;
            end
        end
    end

    initial begin
        int guard;
        int base;
        tests      = 0;
        fails      = 0;
        ack_mode   = 0;
        ready_mode = 0;
        noise_en   = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.num_ch = '0;
        for (int k = 0; k < 256; k++) tap_sum[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single channel returning 100.
        tap_sum[0] = LEN_OUT'(100);
        base = fetch_cnt;
        run_job(1, 3);
        check_output("fetch_once", 32'(fetch_cnt - base), 32'd1);

        // Three channels 10, -4, 7.
        tap_sum[0] = LEN_OUT'(10);
        tap_sum[1] = LEN_OUT'(-4);
        tap_sum[2] = LEN_OUT'(7);
        run_job(3, 7);

        // Zero channels goes straight to DONE.
        run_job(0, 1);

        // Negative result and 25-bit wrap.
        tap_sum[0] = LEN_OUT'(-50);
        run_job(1, 3);
        tap_sum[0] = LEN_OUT'(32'hFF_FFFF);
        tap_sum[1] = LEN_OUT'(1);
        run_job(2, 5);

        // Fetch stall on channel 1, result backpressure and ignored start pulses.
        ack_mode   = 2;
        ready_mode = 2;
        noise_en   = 1'b1;
        tap_sum[0] = LEN_OUT'(3);
        tap_sum[1] = LEN_OUT'(-9);
        tap_sum[2] = LEN_OUT'(40);
        run_job(3, 12);

        // Largest channel count with random sums.
        ack_mode   = 0;
        ready_mode = 0;
        noise_en   = 1'b0;
        for (int k = 0; k < 256; k++) tap_sum[k] = LEN_OUT'($urandom);
        run_job(255, 511);

        // Random jobs with random handshakes.
        ack_mode   = 1;
        ready_mode = 1;
        noise_en   = 1'b1;
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < 8; k++) tap_sum[k] = LEN_OUT'($urandom);
            run_job(int'($urandom_range(6)), -1);
        end

        // Reset during ACC of channel 2, then a clean job.
        ack_mode   = 0;
        ready_mode = 0;
        noise_en   = 1'b0;
        for (int k = 0; k < 4; k++) tap_sum[k] = LEN_OUT'($urandom);
        prep_job(4);
        bus.num_ch = CH_W'(4);
        bus.start  = 1'b1;
        guard      = 0;
        do begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            guard++;
        end while (!(bus.busy && !bus.fetch_req && !bus.res_valid && bus.fetch_ch == CH_W'(2)) && guard < 50);
        if (guard >= 50) report_fail("reach_acc_ch2");
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("idle_after_reset", 32'(bus.busy), 32'd0);
        tap_sum[0] = LEN_OUT'(21);
        tap_sum[1] = LEN_OUT'(-1);
        run_job(2, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
